// File: rtl/pipe_skid_buf_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_skid_buf block:
//   DATA_W      default data width
//   state_e     occupancy state of the two-entry skid buffer
//   state_count maps an occupancy state to its entry count (0..2)
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   function automatic logic [1:0] state_count(input state_e s);
      logic [1:0] c;
      case (s)
         EMPTY:   c = 2'd0;
         ONE:     c = 2'd1;
         FULL:    c = 2'd2;
         default: c = 2'd0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_skid_buf_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf_if
// Producer/consumer handshake bundle of the skid buffer.
//   in_data/in_valid/in_ready    producer side
//   out_data/out_valid/out_ready consumer side
//   count                        number of held entries (0..2)
// Modports:
//   slave  - the buffer's view (accepts from producer, drives consumer)
//   master - the environment's view (drives producer/consumer inputs)
// -----------------------------------------------------------------------------
interface pipe_skid_buf_if #(
   parameter int N = pipe_pkg::DATA_W
);
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   count;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready,
      output count
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  count
   );
endinterface

// File: rtl/pipe_skid_buf_skid_entry.sv
// -----------------------------------------------------------------------------
// skid_entry
// One N-bit storage entry of the skid buffer.
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset, clears the entry to zero
//   i_load   load enable, captures i_d on the next edge
//   i_d      data to capture
//   o_q      stored value
// -----------------------------------------------------------------------------
module skid_entry #(
   parameter int N = pipe_pkg::DATA_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);

   logic [N-1:0] r_q;

   // Entry register: reset wins over load; without load the value is held.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Two-entry skid buffer. The main entry drives out_data; the skid entry
// catches one extra word when the consumer stalls while the buffer already
// holds data. Handshake outputs decode only the registered state, so there is
// no combinational path from out_ready to in_ready.
//   i_clk    clock, rising edge
//   i_reset  synchronous active-low reset (highest priority)
//   i_flush  synchronous flush to EMPTY; input offered that cycle is dropped
//   bus      pipe_skid_buf_if.slave handshake bundle
// -----------------------------------------------------------------------------
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int N = DATA_W
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_flush,
   pipe_skid_buf_if.slave bus
);

   state_e       r_state;
   state_e       w_state_nxt;
   logic         w_in_ready;
   logic         w_out_valid;
   logic         w_in_xfer;
   logic         w_out_xfer;
   logic         w_load_main;
   logic         w_load_skid;
   logic         w_main_from_skid;
   logic [N-1:0] w_main_d;
   logic [N-1:0] w_main_q;
   logic [N-1:0] w_skid_q;

   // Handshake decode from the registered state only.
   always_comb begin
      w_in_ready  = 1'b1;
      w_out_valid = 1'b0;
      case (r_state)
         EMPTY: begin
            w_in_ready  = 1'b1;
            w_out_valid = 1'b0;
         end
         ONE: begin
            w_in_ready  = 1'b1;
            w_out_valid = 1'b1;
         end
         FULL: begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b1;
         end
         default: begin
            w_in_ready  = 1'b1;
            w_out_valid = 1'b0;
         end
      endcase
   end

   assign w_in_xfer  = bus.in_valid  & w_in_ready;
   assign w_out_xfer = w_out_valid   & bus.out_ready;

   // Next-state and entry load decisions. A flush suppresses every load so
   // out_data keeps its last value while the buffer reads as empty.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
      if (i_flush) begin
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_state_nxt = ONE;
                  w_load_main = 1'b1;
               end else begin
                  w_state_nxt = EMPTY;
               end
            end
            ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_state_nxt = ONE;
                  w_load_main = 1'b1;
               end else if (w_in_xfer) begin
                  w_state_nxt = FULL;
                  w_load_skid = 1'b1;
               end else if (w_out_xfer) begin
                  w_state_nxt = EMPTY;
               end else begin
                  w_state_nxt = ONE;
               end
            end
            FULL: begin
               // in_ready is low here, so only the skid word can move up.
               if (w_out_xfer) begin
                  w_state_nxt      = ONE;
                  w_load_main      = 1'b1;
                  w_main_from_skid = 1'b1;
               end else begin
                  w_state_nxt = FULL;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
            end
         endcase
      end
   end

   assign w_main_d = w_main_from_skid ? w_skid_q : bus.in_data;

   // Occupancy state register; reset has priority over flush and handshakes.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   skid_entry #(.N(N)) u_main (
      .i_clk   (i_clk),
      .i_rst_n (i_reset),
      .i_load  (w_load_main),
      .i_d     (w_main_d),
      .o_q     (w_main_q)
   );

   skid_entry #(.N(N)) u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_reset),
      .i_load  (w_load_skid),
      .i_d     (bus.in_data),
      .o_q     (w_skid_q)
   );

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_main_q;
   assign bus.count     = state_count(r_state);

endmodule

// File: tb/tb_pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_buf
// Self-checking bench: a queue model of the buffer contents predicts every
// output each cycle; directed sequences pin known literal values; a random
// stall run checks ordered, lossless delivery of 1000 items.
// -----------------------------------------------------------------------------
module tb_pipe_skid_buf;

   logic clk;
   logic reset;
   logic flush;

   pipe_skid_buf_if #(.N(16)) bus ();

   pipe_skid_buf #(.N(16)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .i_flush (flush),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;
   logic [15:0] q[$];        // model: held entries, oldest first
   logic [15:0] m_last;      // model: value out_data must show
   logic [15:0] deliver[$];  // model: every delivered word in order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the queue model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
         chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
         chk("count",     32'(bus.count),     32'(q.size()));
         chk("out_data",  32'(bus.out_data),  32'(m_last));
      end
   end

   // Drive one cycle of inputs, advance the model to the post-edge state,
   // then wait until just after the following falling edge.
   task automatic step(input logic rst, input logic fl, input logic iv,
                       input logic [15:0] d, input logic ordy);
      logic [15:0] got;
      reset         = rst;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      if (!rst) begin
         q.delete();
         m_last = 16'h0000;
      end else begin
         logic ov;
         logic ir;
         ov = (q.size() > 0);
         ir = (q.size() < 2);
         if (ov && ordy) begin
            got = q.pop_front();
            deliver.push_back(got);
         end
         if (fl) begin
            q.delete();
         end else if (iv && ir) begin
            q.push_back(d);
         end
         if (q.size() > 0) m_last = q[0];
      end
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      int seq;
      int cycles;
      int base;
      int bad;
      bit cc_seen;
      reset         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.out_ready = 1'b0;
      m_last        = 16'h0000;
      @(negedge clk);
      #1;

      // Reset state.
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      chk_en = 1'b1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_data",  32'(bus.out_data),  32'h0000);
      chk("rst_count",     32'(bus.count),     32'd0);

      // One-cycle latency from EMPTY.
      step(1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
      chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_out_data",  32'(bus.out_data),  32'h1234);
      chk("lat_count",     32'(bus.count),     32'd1);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

      // Stall fills the skid entry; release drains in order.
      step(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b0);
      chk("full_count",    32'(bus.count),    32'd2);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_data",     32'(bus.out_data), 32'hAAAA);
      step(1'b1, 1'b0, 1'b1, 16'hDDDD, 1'b0);
      chk("stall_stable",  32'(bus.out_data), 32'hAAAA);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("drain_second",  32'(bus.out_data), 32'hBBBB);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("drain_valid",   32'(bus.out_valid), 32'd0);
      chk("drain_retain",  32'(bus.out_data),  32'hBBBB);

      // Sustained streaming, one word per cycle.
      for (int k = 1; k <= 16; k++) begin
         step(1'b1, 1'b0, 1'b1, 16'(k), 1'b1);
         chk("stream_valid", 32'(bus.out_valid), 32'd1);
         chk("stream_data",  32'(bus.out_data),  32'(k));
      end
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("stream_end", 32'(bus.out_valid), 32'd0);

      // Flush from FULL drops the offered word.
      step(1'b1, 1'b0, 1'b1, 16'h1111, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'h2222, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'hCCCC, 1'b0);
      chk("flush_count",    32'(bus.count),     32'd0);
      chk("flush_valid",    32'(bus.out_valid), 32'd0);
      chk("flush_in_ready", 32'(bus.in_ready),  32'd1);
      cc_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
         if (bus.out_valid && bus.out_data == 16'hCCCC) cc_seen = 1'b1;
      end
      chk("flush_dropped", 32'(cc_seen), 32'd0);

      // Reset together with flush while FULL.
      step(1'b1, 1'b0, 1'b1, 16'h3333, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'h4444, 1'b0);
      step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1);
      chk("rstfl_data",  32'(bus.out_data), 32'h0000);
      chk("rstfl_count", 32'(bus.count),    32'd0);

      // Random-stall run of 1000 sequence-numbered items.
      base   = deliver.size();
      seq    = 0;
      cycles = 0;
      while ((seq < 1000 || q.size() > 0) && cycles < 20000) begin
         logic iv;
         logic ordy;
         logic acc;
         iv   = (seq < 1000) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         acc  = iv && (q.size() < 2);
         step(1'b1, 1'b0, iv, 16'(seq), ordy);
         if (acc) seq++;
         cycles++;
      end
      chk("rand_timeout",   32'(cycles < 20000), 32'd1);
      chk("rand_delivered", 32'(deliver.size() - base), 32'd1000);
      bad = 0;
      for (int i = 0; i < deliver.size() - base; i++) begin
         if (deliver[base + i] != 16'(i)) bad++;
      end
      chk("rand_order", 32'(bad), 32'd0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
